// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: access-size codes, stage FSM states, MEM/WB payload,
// and the byte-enable / write-data lane helpers.
package mips_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic        vld;
    logic        mem_to_reg;
    logic        data_c;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data_mem;
    logic [31:0] pc_adder;
  } wb_t;

  // Size code 11 falls into the word lane pattern.
  function automatic logic [3:0] mem_be(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 4'b0001 << addr_lo;
      MEM_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mem_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      MEM_BYTE: return {4{data[7:0]}};
      MEM_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data lane select and sign/zero extension; purely combinational, 0 cycles,
// no flow control of its own.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_dat;
  logic [15:0] half_dat;

  always_comb begin
    byte_dat = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_dat = rdata[7:0];
      2'b01:   byte_dat = rdata[15:8];
      2'b10:   byte_dat = rdata[23:16];
      default: byte_dat = rdata[31:24];
    endcase
    half_dat = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      MEM_BYTE: result = {{24{byte_dat[7]  & ~load_unsigned}}, byte_dat};
      MEM_HALF: result = {{16{half_dat[15] & ~load_unsigned}}, half_dat};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: EX/MEM -> MEM/WB in 1 edge, memory ops 2+ edges (one per ack wait);
// stalls upstream while an access is outstanding. Optional MEM_MISALIGN_TRAP_EN flags misaligned half/word.
module mem_access_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_pc_adder,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic        ex_MemtoReg,
  input  logic        ex_DataC,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_MemtoReg,
  output logic        wb_DataC,
  output logic        wb_reg_write,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data_mem,
  output logic [31:0] wb_pc_adder,
  output logic [4:0]  wb_write_reg,
  output logic        misalign
);

  state_t      state;
  wb_t         wb_q;
  wb_t         req_wb;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  wb_t         ex_wb;
  wb_t         ack_wb;
  logic [31:0] load_dat;
  logic        mem_op;
  logic        misaligned;
  logic        busy;

  assign busy   = (state == BUSY);
  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op &
                      (((ex_mem_size == MEM_HALF) & ex_alu_result[0]) |
                       (ex_mem_size[1] & (|ex_alu_result[1:0])));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    ex_wb               = '0;
    ex_wb.vld           = ex_valid;
    ex_wb.mem_to_reg    = ex_MemtoReg;
    ex_wb.data_c        = ex_DataC;
    ex_wb.reg_write     = ex_reg_write;
    ex_wb.write_reg     = ex_write_reg;
    ex_wb.alu_result    = ex_alu_result;
    ex_wb.pc_adder      = ex_pc_adder;

    ack_wb               = req_wb;
    ack_wb.read_data_mem = req_we ? 32'h0 : load_dat;
  end

  load_align u_load_align (
    .rdata         (dmem_rdata),
    .addr_lo       (req_wb.alu_result[1:0]),
    .size          (req_size),
    .load_unsigned (req_uns),
    .result        (load_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wb_q      <= '0;
      req_wb    <= '0;
      req_size  <= MEM_BYTE;
      req_uns   <= 1'b0;
      req_we    <= 1'b0;
      req_be    <= 4'h0;
      req_wdata <= 32'h0;
    end else if (!busy) begin
      if (mem_op && !misaligned) begin
        req_wb    <= ex_wb;
        req_size  <= ex_mem_size;
        req_uns   <= ex_mem_unsigned;
        req_we    <= ex_mem_write;
        req_be    <= mem_be(ex_mem_size, ex_alu_result[1:0]);
        req_wdata <= mem_wdata(ex_mem_size, ex_store_data);
        state     <= BUSY;
        wb_q      <= '0;
      end else if (mem_op) begin
        wb_q <= '0;
      end else begin
        wb_q <= ex_wb;
      end
    end else if (dmem_ack) begin
      wb_q  <= ack_wb;
      state <= IDLE;
    end else begin
      wb_q <= '0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= !busy && misaligned;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign dmem_req   = busy;
  assign dmem_we    = busy & req_we;
  assign dmem_addr  = {req_wb.alu_result[31:2], 2'b00};
  assign dmem_be    = req_be;
  assign dmem_wdata = req_wdata;

  assign mem_stall  = (!busy && mem_op && !misaligned) || (busy && !dmem_ack);

  assign wb_valid         = wb_q.vld;
  assign wb_MemtoReg      = wb_q.mem_to_reg;
  assign wb_DataC         = wb_q.data_c;
  assign wb_reg_write     = wb_q.reg_write;
  assign wb_write_reg     = wb_q.write_reg;
  assign wb_alu_result    = wb_q.alu_result;
  assign wb_read_data_mem = wb_q.read_data_mem;
  assign wb_pc_adder      = wb_q.pc_adder;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; inputs change at negedge or posedge+1, outputs sampled off-edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc_adder;
  logic        ex_mem_read, ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic        ex_MemtoReg, ex_DataC, ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        wb_valid, wb_MemtoReg, wb_DataC, wb_reg_write;
  logic [31:0] wb_alu_result, wb_read_data_mem, wb_pc_adder;
  logic [4:0]  wb_write_reg;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_addr, cap_wdata, cap_rd, cap_alu;
  logic [3:0]  cap_be;
  logic        cap_we, hold_ok;
  logic [4:0]  cap_wreg;
  int          stall_cnt, wbv_cnt;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_pc_adder(ex_pc_adder),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_MemtoReg(ex_MemtoReg), .ex_DataC(ex_DataC),
    .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg),
    .wb_DataC(wb_DataC), .wb_reg_write(wb_reg_write), .wb_alu_result(wb_alu_result),
    .wb_read_data_mem(wb_read_data_mem), .wb_pc_adder(wb_pc_adder),
    .wb_write_reg(wb_write_reg), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic [1:0] sz,
                       input logic u, input logic [4:0] wreg);
    ex_valid        = v;
    ex_alu_result   = a;
    ex_store_data   = sd;
    ex_pc_adder     = a + 32'd8;
    ex_mem_read     = rd;
    ex_mem_write    = wr;
    ex_mem_size     = sz;
    ex_mem_unsigned = u;
    ex_MemtoReg     = rd;
    ex_DataC        = 1'b0;
    ex_reg_write    = ~wr;
    ex_write_reg    = wreg;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
  endtask

  // Presents one memory op, answers it after 'waits' ack-less BUSY cycles, then drains one cycle.
  task automatic do_mem(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic u,
                        input logic [4:0] wreg, input int waits, input logic [31:0] rdata);
    stall_cnt = 0;
    wbv_cnt   = 0;
    hold_ok   = 1'b1;
    @(negedge clk);
    drive(1'b1, a, sd, rd, wr, sz, u, wreg);
    #1 if (mem_stall) stall_cnt++;
    @(posedge clk); #1;
    if (wb_valid) wbv_cnt++;
    cap_addr  = dmem_addr;
    cap_be    = dmem_be;
    cap_wdata = dmem_wdata;
    cap_we    = dmem_we;
    for (int i = 0; i < waits; i++) begin
      if (mem_stall) stall_cnt++;
      if (!dmem_req || dmem_addr != cap_addr || dmem_be != cap_be || dmem_wdata != cap_wdata)
        hold_ok = 1'b0;
      @(posedge clk); #1;
      if (wb_valid) wbv_cnt++;
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1 if (mem_stall) stall_cnt++;
    @(posedge clk); #1;
    if (wb_valid) wbv_cnt++;
    cap_rd   = wb_read_data_mem;
    cap_alu  = wb_alu_result;
    cap_wreg = wb_write_reg;
    dmem_ack = 1'b0;
    idle_in();
    @(posedge clk); #1;
    if (wb_valid) wbv_cnt++;
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("reset misalign", {31'd0, misalign}, 32'd0);
    chk("reset wb_alu_result", wb_alu_result, 32'd0);

    // ALU op passes straight through in one edge
    @(negedge clk);
    drive(1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5);
    #1;
    chk("alu stall", {31'd0, mem_stall}, 32'd0);
    chk("alu req idle", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    chk("alu wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu wb_alu_result", wb_alu_result, 32'h0000_1234);
    chk("alu wb_pc_adder", wb_pc_adder, 32'h0000_123C);
    chk("alu wb_write_reg", {27'd0, wb_write_reg}, 32'd5);
    chk("alu wb_read_data", wb_read_data_mem, 32'd0);
    chk("alu req after", {31'd0, dmem_req}, 32'd0);

    // lb / lbu at 0x1003, lane 3 holds 0x80
    do_mem(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd8, 0, 32'h80FF_FFFF);
    chk("lb addr", cap_addr, 32'h0000_1000);
    chk("lb be", {28'd0, cap_be}, 32'h8);
    chk("lb we", {31'd0, cap_we}, 32'd0);
    chk("lb data", cap_rd, 32'hFFFF_FF80);
    chk("lb wb_alu", cap_alu, 32'h0000_1003);
    chk("lb stall cycles", stall_cnt, 32'd1);
    chk("lb wb count", wbv_cnt, 32'd1);
    do_mem(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd8, 0, 32'h80FF_FFFF);
    chk("lbu data", cap_rd, 32'h0000_0080);

    // lh signed at 0x2002, upper half lane
    do_mem(32'h0000_2002, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd3, 1, 32'h9ABC_1234);
    chk("lh be", {28'd0, cap_be}, 32'hC);
    chk("lh data", cap_rd, 32'hFFFF_9ABC);

    // sh at 0x2002 with three wait cycles
    do_mem(32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 3, 32'hFFFF_FFFF);
    chk("sh be", {28'd0, cap_be}, 32'hC);
    chk("sh wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh we", {31'd0, cap_we}, 32'd1);
    chk("sh hold stable", {31'd0, hold_ok}, 32'd1);
    chk("sh stall cycles", stall_cnt, 32'd4);
    chk("sh wb count", wbv_cnt, 32'd1);
    chk("sh read data zero", cap_rd, 32'd0);

    // sb at 0x3001
    do_mem(32'h0000_3001, 32'h1234_56A5, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 0, 32'h0);
    chk("sb be", {28'd0, cap_be}, 32'h2);
    chk("sb wdata", cap_wdata, 32'hA5A5_A5A5);

    // reset while BUSY, then a late ack must not produce output
    @(negedge clk);
    drive(1'b1, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd7);
    @(posedge clk); #1;
    chk("rst busy req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst busy req drop", {31'd0, dmem_req}, 32'd0);
    chk("rst busy wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst busy stall", {31'd0, mem_stall}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late ack wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("late ack req", {31'd0, dmem_req}, 32'd0);

    // lw then addu back-to-back
    @(negedge clk);
    drive(1'b1, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9);
    @(posedge clk); #1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("b2b lw wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b lw data", wb_read_data_mem, 32'hCAFE_F00D);
    chk("b2b lw reg", {27'd0, wb_write_reg}, 32'd9);
    drive(1'b1, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd10);
    #1 chk("b2b addu stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("b2b addu wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b addu alu", wb_alu_result, 32'h0000_0077);
    chk("b2b addu reg", {27'd0, wb_write_reg}, 32'd10);
    chk("b2b addu read data", wb_read_data_mem, 32'd0);
    idle_in();
    @(posedge clk); #1;
    chk("b2b no duplicate", {31'd0, wb_valid}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    drive(1'b1, 32'h0000_1002, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4);
    #1;
    chk("mis stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("mis flag", {31'd0, misalign}, 32'd1);
    chk("mis no req", {31'd0, dmem_req}, 32'd0);
    chk("mis wb_valid", {31'd0, wb_valid}, 32'd0);
    idle_in();
    @(posedge clk); #1;
    chk("mis flag pulse", {31'd0, misalign}, 32'd0);
    chk("mis no req later", {31'd0, dmem_req}, 32'd0);
`else
    do_mem(32'h0000_1002, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 0, 32'h0BAD_CAFE);
    chk("unaligned lw addr", cap_addr, 32'h0000_1000);
    chk("unaligned lw be", {28'd0, cap_be}, 32'hF);
    chk("unaligned lw data", cap_rd, 32'h0BAD_CAFE);
    chk("misalign tied", {31'd0, misalign}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
